alu_cmd_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the 32-bit combinational ALU (AND/OR/ADD/SUB/COMP). Accepts register-addressed commands over a valid/ready handshake, reads operands from an internal 8x32 register file, drives the ALU opcode and operand inputs, registers the ALU result, writes it back to the destination register, and reports it on a response handshake. Also provides a direct load port for preloading registers.

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_cmd_sequencer_if.sv | 46 ++++
 rtl/alu_seq_regfile.sv | 42 ++++
 rtl/alu_cmd_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants and FSM state type for the ALU command sequencer.
package alu_seq_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NREGS_DEF = 8;
  localparam int unsigned ADDR_W    = $clog2(NREGS_DEF);
  localparam int unsigned OP_W      = 3;
  localparam int unsigned IMM_W     = 16;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
  localparam logic [OP_W-1:0] OP_COMP = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command/response handshake bundle of the ALU command sequencer.
// ALU_SEQ_IMM_EN adds the immediate-operand command fields.
interface alu_cmd_sequencer_if
  import alu_seq_pkg::*;
#(
  parameter int unsigned NREGS = 8
);
  localparam int unsigned AW = $clog2(NREGS);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [AW-1:0]     cmd_rd;
  logic [AW-1:0]     cmd_rs1;
  logic [AW-1:0]     cmd_rs2;
`ifdef ALU_SEQ_IMM_EN
  logic              cmd_use_imm;
  logic [IMM_W-1:0]  cmd_imm;
`endif
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic [AW-1:0]     rsp_rd;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
`ifdef ALU_SEQ_IMM_EN
    output cmd_use_imm, cmd_imm,
`endif
    input  cmd_ready,
    input  rsp_valid, rsp_result, rsp_zero, rsp_rd,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
`ifdef ALU_SEQ_IMM_EN
    input  cmd_use_imm, cmd_imm,
`endif
    output cmd_ready,
    output rsp_valid, rsp_result, rsp_zero, rsp_rd,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_seq_regfile.sv
// NREGS x 32 register file: two async read ports, r0 reads as zero.
// Writeback and load ports; the top resolves same-address priority.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int unsigned NREGS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     ld_en,
  input  logic [$clog2(NREGS)-1:0] ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic [$clog2(NREGS)-1:0] ra1,
  output logic [DATA_W-1:0]        rd1,
  input  logic [$clog2(NREGS)-1:0] ra2,
  output logic [DATA_W-1:0]        rd2
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (ld_en && (ld_addr != '0)) begin
        mem[ld_addr] <= ld_data;
      end
      if (wb_en && (wb_addr != '0)) begin
        mem[wb_addr] <= wb_data;
      end
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Sequencer upstream of a combinational ALU: accept, execute, respond.
// Optional immediate operand 2 enabled by defining ALU_SEQ_IMM_EN.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned NREGS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_cmd_sequencer_if.slave       seq,
  input  logic                     ld_en,
  input  logic [$clog2(NREGS)-1:0] ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  output logic [OP_W-1:0]          alu_opcode,
  output logic [DATA_W-1:0]        alu_op1,
  output logic [DATA_W-1:0]        alu_op2,
  input  logic [DATA_W-1:0]        alu_result,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(NREGS);

  seq_state_t        state, state_n;
  logic              accept;
  logic              wb_en;
  logic              ld_we;
  logic [DATA_W-1:0] rd1, rd2, opb;

  logic [OP_W-1:0]   op_q;
  logic [AW-1:0]     rd_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_zero_q;
  logic [AW-1:0]     rsp_rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    accept        = 1'b0;
    wb_en         = 1'b0;
    seq.cmd_ready = 1'b0;
    seq.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        seq.cmd_ready = 1'b1;
        if (seq.cmd_valid) begin
          accept  = 1'b1;
          state_n = EXEC;
        end
      end
      EXEC: begin
        wb_en   = 1'b1;
        state_n = RESP;
      end
      RESP: begin
        seq.rsp_valid = 1'b1;
        if (seq.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef ALU_SEQ_IMM_EN
  assign opb = seq.cmd_use_imm ? {{(DATA_W-IMM_W){1'b0}}, seq.cmd_imm} : rd2;
`else
  assign opb = rd2;
`endif

  // Writeback owns a contended address; a load elsewhere proceeds alongside it.
  assign ld_we = ld_en && !(wb_en && (ld_addr == rd_q));

  alu_seq_regfile #(
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wb_en   (wb_en),
    .wb_addr (rd_q),
    .wb_data (alu_result),
    .ld_en   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .ra1     (seq.cmd_rs1),
    .rd1     (rd1),
    .ra2     (seq.cmd_rs2),
    .rd2     (rd2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= '0;
      rd_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_rd_q     <= '0;
    end else begin
      if (accept) begin
        op_q <= seq.cmd_op;
        rd_q <= seq.cmd_rd;
        a_q  <= rd1;
        b_q  <= opb;
      end
      if (wb_en) begin
        rsp_result_q <= alu_result;
        rsp_zero_q   <= (alu_result == '0);
        rsp_rd_q     <= rd_q;
      end
    end
  end

  // Latches only change on accept, so the ALU inputs hold outside EXEC.
  assign alu_opcode     = op_q;
  assign alu_op1        = a_q;
  assign alu_op2        = b_q;
  assign seq.rsp_result = rsp_result_q;
  assign seq.rsp_zero   = rsp_zero_q;
  assign seq.rsp_rd     = rsp_rd_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU and register model.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  typedef struct {
    bit          en;
    logic [2:0]  addr;
    logic [31:0] data;
  } ld_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mref [8];

  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.NREGS(8)) sif ();

  alu_cmd_sequencer #(.NREGS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .seq        (sif),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .alu_opcode (alu_opcode),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_result (alu_result),
    .busy       (busy)
  );

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_COMP: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_opcode, alu_op1, alu_op2);

  function automatic logic [31:0] rref(input logic [2:0] addr);
    return (addr == 3'd0) ? 32'd0 : mref[addr];
  endfunction

  task automatic mwrite(input logic [2:0] addr, input logic [31:0] data);
    if (addr != 3'd0) mref[addr] = data;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic set_ld(input ld_t l);
    ld_en   = l.en;
    ld_addr = l.addr;
    ld_data = l.data;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, sif.cmd_ready, 1);
    chk({tag, "_rsp_valid"}, sif.rsp_valid, 0);
    chk({tag, "_rsp_result"}, sif.rsp_result, 0);
    chk({tag, "_rsp_zero"}, sif.rsp_zero, 0);
    chk({tag, "_rsp_rd"}, sif.rsp_rd, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_alu_opcode"}, alu_opcode, 0);
    chk({tag, "_alu_op1"}, alu_op1, 0);
    chk({tag, "_alu_op2"}, alu_op2, 0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mref[i] = 32'd0;
  endtask

  task automatic load(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
    mwrite(addr, data);
  endtask

  // la: load during the accept cycle, lx: during EXEC, lr: at start of RESP.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input bit use_imm, input logic [15:0] imm, input int unsigned hold,
                         input ld_t la, input ld_t lx, input ld_t lr,
                         output logic [31:0] res);
    logic [31:0] a, b, exp;
    a = rref(rs1);
    b = rref(rs2);
`ifdef ALU_SEQ_IMM_EN
    if (use_imm) b = {16'h0, imm};
`else
    if (use_imm && (imm != imm)) b = 32'd0;
`endif
    exp = alu_fn(op, a, b);

    @(negedge clk);
    sif.cmd_valid = 1'b1;
    sif.cmd_op = op; sif.cmd_rd = rd; sif.cmd_rs1 = rs1; sif.cmd_rs2 = rs2;
`ifdef ALU_SEQ_IMM_EN
    sif.cmd_use_imm = use_imm; sif.cmd_imm = imm;
`endif
    set_ld(la);
    chk({tag, "_ready"}, sif.cmd_ready, 1);

    @(negedge clk);
    if (la.en) mwrite(la.addr, la.data);
    sif.cmd_valid = 1'b0;
    set_ld(lx);
    chk({tag, "_exec_busy"}, busy, 1);
    chk({tag, "_exec_rsp_valid"}, sif.rsp_valid, 0);
    chk({tag, "_exec_cmd_ready"}, sif.cmd_ready, 0);
    chk({tag, "_alu_opcode"}, alu_opcode, op);
    chk({tag, "_alu_op1"}, alu_op1, a);
    chk({tag, "_alu_op2"}, alu_op2, b);

    @(negedge clk);
    if (lx.en && (lx.addr != rd)) mwrite(lx.addr, lx.data);
    mwrite(rd, exp);
    set_ld(lr);
    chk({tag, "_rsp_valid"}, sif.rsp_valid, 1);
    chk({tag, "_rsp_result"}, sif.rsp_result, exp);
    chk({tag, "_rsp_zero"}, sif.rsp_zero, (exp == 32'd0) ? 1 : 0);
    chk({tag, "_rsp_rd"}, sif.rsp_rd, rd);
    res = sif.rsp_result;

    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      ld_en = 1'b0;
      chk({tag, "_hold_valid"}, sif.rsp_valid, 1);
      chk({tag, "_hold_result"}, sif.rsp_result, exp);
      chk({tag, "_hold_rd"}, sif.rsp_rd, rd);
      chk({tag, "_hold_cmd_ready"}, sif.cmd_ready, 0);
    end

    sif.rsp_ready = 1'b1;
    @(negedge clk);
    sif.rsp_ready = 1'b0;
    ld_en = 1'b0;
    if (lr.en) mwrite(lr.addr, lr.data);
    chk({tag, "_done_valid"}, sif.rsp_valid, 0);
    chk({tag, "_done_ready"}, sif.cmd_ready, 1);
    chk({tag, "_done_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sif.cmd_valid = 1'b0;
    sif.rsp_ready = 1'b0;
    ld_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ld_t nold, l;
    ld_t la, lx, lr;
    logic [31:0] r;
    logic [2:0] op, rd, rs1, rs2;

    nold = '{1'b0, 3'd0, 32'd0};
    rst = 1'b1;
    sif.cmd_valid = 1'b0; sif.rsp_ready = 1'b0;
    sif.cmd_op = '0; sif.cmd_rd = '0; sif.cmd_rs1 = '0; sif.cmd_rs2 = '0;
`ifdef ALU_SEQ_IMM_EN
    sif.cmd_use_imm = 1'b0; sif.cmd_imm = '0;
`endif
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    do_reset();
    chk_reset_outputs("reset");

    // Basic datapath
    load(3'd1, 32'h0000_0005);
    load(3'd2, 32'h0000_0003);
    run_cmd("add", OP_ADD, 3'd3, 3'd1, 3'd2, 0, 16'h0, 0, nold, nold, nold, r);
    chk("add_value", r, 32'h8);
    run_cmd("or", OP_OR, 3'd4, 3'd3, 3'd0, 0, 16'h0, 0, nold, nold, nold, r);
    chk("or_value", r, 32'h8);
    run_cmd("sub0", OP_SUB, 3'd5, 3'd1, 3'd1, 0, 16'h0, 0, nold, nold, nold, r);
    chk("sub0_value", r, 32'h0);
    run_cmd("comp", OP_COMP, 3'd6, 3'd2, 3'd1, 0, 16'h0, 0, nold, nold, nold, r);
    chk("comp_value", r, 32'h1);
    run_cmd("add_r0", OP_ADD, 3'd0, 3'd1, 3'd2, 0, 16'h0, 0, nold, nold, nold, r);
    chk("add_r0_value", r, 32'h8);
    run_cmd("read_r0", OP_OR, 3'd4, 3'd0, 3'd0, 0, 16'h0, 0, nold, nold, nold, r);
    chk("read_r0_value", r, 32'h0);
    run_cmd("op7", 3'd7, 3'd6, 3'd1, 3'd2, 0, 16'h0, 0, nold, nold, nold, r);
    chk("op7_value", r, 32'h0);

    // Backpressure with a concurrent load
    lr = '{1'b1, 3'd7, 32'hDEAD_BEEF};
    run_cmd("bp", OP_ADD, 3'd3, 3'd1, 3'd2, 0, 16'h0, 10, nold, nold, lr, r);
    run_cmd("read_r7", OP_OR, 3'd4, 3'd7, 3'd0, 0, 16'h0, 0, nold, nold, nold, r);
    chk("read_r7_value", r, 32'hDEAD_BEEF);

    // Writeback vs load collisions
    lx = '{1'b1, 3'd5, 32'h1111_1111};
    run_cmd("coll_same", OP_ADD, 3'd5, 3'd1, 3'd2, 0, 16'h0, 0, nold, lx, nold, r);
    run_cmd("read_r5", OP_OR, 3'd4, 3'd5, 3'd0, 0, 16'h0, 0, nold, nold, nold, r);
    chk("read_r5_value", r, 32'h8);
    lx = '{1'b1, 3'd6, 32'h2222_2222};
    run_cmd("coll_diff", OP_ADD, 3'd5, 3'd1, 3'd2, 0, 16'h0, 0, nold, lx, nold, r);
    run_cmd("read_r6", OP_OR, 3'd4, 3'd6, 3'd0, 0, 16'h0, 0, nold, nold, nold, r);
    chk("read_r6_value", r, 32'h2222_2222);

    // Read-before-write at accept
    la = '{1'b1, 3'd1, 32'h0000_0064};
    run_cmd("rbw", OP_ADD, 3'd3, 3'd1, 3'd2, 0, 16'h0, 0, la, nold, nold, r);
    chk("rbw_value", r, 32'h8);
    run_cmd("read_r1", OP_OR, 3'd4, 3'd1, 3'd0, 0, 16'h0, 0, nold, nold, nold, r);
    chk("read_r1_value", r, 32'h64);

    // Reset during EXEC
    load(3'd1, 32'h0000_0005);
    @(negedge clk);
    sif.cmd_valid = 1'b1; sif.cmd_op = OP_ADD; sif.cmd_rd = 3'd3;
    sif.cmd_rs1 = 3'd1; sif.cmd_rs2 = 3'd2;
    @(negedge clk);
    sif.cmd_valid = 1'b0;
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", sif.rsp_valid, 0);
    chk("midrst_alu_op1", alu_op1, 0);
    chk("midrst_alu_opcode", alu_opcode, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    chk_reset_outputs("midrst");
    run_cmd("read_r3", OP_OR, 3'd4, 3'd3, 3'd0, 0, 16'h0, 0, nold, nold, nold, r);
    chk("read_r3_value", r, 32'h0);

`ifdef ALU_SEQ_IMM_EN
    load(3'd1, 32'h1234_5678);
    run_cmd("imm", OP_AND, 3'd2, 3'd1, 3'd0, 1, 16'hFFFF, 0, nold, nold, nold, r);
    chk("imm_value", r, 32'h0000_5678);
`endif

    // Randomized traffic against the model
    for (int i = 1; i < 8; i++) load(3'(i), $urandom);
    for (int n = 0; n < 40; n++) begin
      op  = 3'($urandom_range(0, 7));
      rd  = 3'($urandom_range(0, 7));
      rs1 = 3'($urandom_range(0, 7));
      rs2 = 3'($urandom_range(0, 7));
      l = '{($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), $urandom};
      la = l;
      l = '{($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), $urandom};
      lx = l;
      l = '{($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), $urandom};
      lr = l;
      run_cmd("rand", op, rd, rs1, rs2, bit'($urandom_range(0, 1)), 16'($urandom),
              $urandom_range(0, 3), la, lx, lr, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
